router_in_port: RTL and testbench

ROUTER_IN_PORT -- requirements
Module: router_in_port

---
 rtl/router_in_port.sv | 208 ++++++++++++++++++++
 tb/tb_router_in_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_in_port.sv
// Router ingress port: frames sa/sa_valid packets, stages payload into a show-ahead FIFO toward the fabric.
// Optional packet/drop statistics are built only when ROUTER_IN_PORT_STATS_EN is defined.
`timescale 1ns/1ps
module router_in_port #(
  parameter int DEPTH       = 32,
  parameter int MAX_PAYLOAD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sa,
  input  logic        sa_valid,
  output logic [7:0]  out_data,
  output logic [2:0]  out_dest,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PTRW = AW + 1;
  localparam int PW   = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_r;
  logic              sa_prev_r;
  logic [2:0]        dest_r;
  logic [7:0]        stage_data_r;
  logic              stage_valid_r;
  logic [PW-1:0]     pay_cnt_r;
  logic [PTRW-1:0]   wr_ptr_r;
  logic [PTRW-1:0]   rd_ptr_r;
  logic [11:0]       mem_r [DEPTH];

  logic [PTRW-1:0]   mem_cnt_s;
  logic [PTRW-1:0]   free_s;
  logic              admit_s;
  logic              pay_full_s;
  logic              wr_en_s;
  logic              wr_eop_s;
  logic              pkt_inc_s;
  logic              drop_inc_s;
  logic              load_s;

  // Admission looks at free space left after the staged byte lands.
  assign mem_cnt_s  = wr_ptr_r - rd_ptr_r;
  assign free_s     = PTRW'(DEPTH) - mem_cnt_s - PTRW'(stage_valid_r);
  assign admit_s    = (free_s >= PTRW'(MAX_PAYLOAD));
  assign pay_full_s = (pay_cnt_r == PW'(MAX_PAYLOAD));
  assign load_s     = (wr_ptr_r != rd_ptr_r) && (!out_valid || out_ready);

  // Decode the FIFO write and the statistics events for this edge.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_eop_s   = 1'b0;
    pkt_inc_s  = 1'b0;
    drop_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sa_valid && !sa_prev_r && !admit_s) begin
          drop_inc_s = 1'b1;
        end else begin
          drop_inc_s = 1'b0;
        end
      end
      RECV: begin
        if (sa_valid) begin
          if (pay_full_s) begin
            wr_en_s    = 1'b1;
            wr_eop_s   = 1'b1;
            pkt_inc_s  = 1'b1;
            drop_inc_s = 1'b1;
          end else begin
            wr_en_s    = stage_valid_r;
          end
        end else begin
          // A header with no payload leaves nothing staged and counts as a drop.
          wr_en_s    = stage_valid_r;
          wr_eop_s   = 1'b1;
          pkt_inc_s  = stage_valid_r;
          drop_inc_s = !stage_valid_r;
        end
      end
      DROP: begin
        wr_en_s = 1'b0;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Framing FSM, staging register and FIFO write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      sa_prev_r     <= 1'b1;
      dest_r        <= 3'd0;
      stage_data_r  <= 8'd0;
      stage_valid_r <= 1'b0;
      pay_cnt_r     <= '0;
      wr_ptr_r      <= '0;
    end else begin
      // sa_prev_r resets high so a packet already in flight at release is discarded.
      sa_prev_r <= sa_valid;
      case (state_r)
        IDLE: begin
          if (sa_valid) begin
            if (sa_prev_r) begin
              state_r <= DROP;
            end else if (admit_s) begin
              state_r   <= RECV;
              dest_r    <= {1'b0, sa[1:0]} + 3'd1;
              pay_cnt_r <= '0;
            end else begin
              state_r <= DROP;
            end
          end
        end
        RECV: begin
          if (sa_valid) begin
            if (pay_full_s) begin
              state_r       <= DROP;
              stage_valid_r <= 1'b0;
            end else begin
              stage_data_r  <= sa;
              stage_valid_r <= 1'b1;
              pay_cnt_r     <= pay_cnt_r + PW'(1);
            end
          end else begin
            stage_valid_r <= 1'b0;
            state_r       <= IDLE;
          end
        end
        DROP: begin
          if (!sa_valid) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTRW'(1);
      end
    end
  end

  // Payload storage, left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {wr_eop_s, dest_r, stage_data_r};
    end
  end

  // Output register forms the FIFO head; it refills whenever it empties or is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r  <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_dest  <= 3'd0;
      out_eop   <= 1'b0;
    end else if (load_s) begin
      {out_eop, out_dest, out_data} <= mem_r[rd_ptr_r[AW-1:0]];
      out_valid <= 1'b1;
      rd_ptr_r  <= rd_ptr_r + PTRW'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ROUTER_IN_PORT_STATS_EN
  logic [15:0] pkt_cnt_r;
  logic [15:0] drop_cnt_r;

  // Saturating packet and drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_r  <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (pkt_inc_s && (pkt_cnt_r != 16'hFFFF)) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end
      if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_r;
  assign drop_cnt = drop_cnt_r;
`else
  logic stats_unused_s;
  assign stats_unused_s = pkt_inc_s | drop_inc_s;
  assign pkt_cnt  = 16'd0;
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_router_in_port.sv
// Randomized bench for router_in_port: a packet-level queue model predicts every delivered byte and the counters.
`timescale 1ns/1ps
module tb_router_in_port;

  localparam int DEPTH = 32;
  localparam int MAXP  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sa;
  logic        sa_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_dest;
  logic        out_eop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  router_in_port #(.DEPTH(DEPTH), .MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .reset(reset), .sa(sa), .sa_valid(sa_valid),
    .out_data(out_data), .out_dest(out_dest), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q [$];
  int exp_pkt  = 0;
  int exp_drop = 0;
  int rdy_mode = 0;
  logic [7:0] pay [0:31];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int exp_c(input int v);
`ifdef ROUTER_IN_PORT_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Packet-level model: admission by free space, truncation, header-only drop.
  function automatic void model_packet(input logic [7:0] hdr, input int n);
    logic [2:0] d;
    int k;
    d = {1'b0, hdr[1:0]} + 3'd1;
    if (DEPTH - exp_q.size() < MAXP) begin
      exp_drop++;
    end else if (n == 0) begin
      exp_drop++;
    end else begin
      k = (n > MAXP) ? MAXP : n;
      for (int i = 0; i < k; i++) exp_q.push_back({(i == k - 1), d, pay[i]});
      exp_pkt++;
      if (n > MAXP) exp_drop++;
    end
  endfunction

  // Ready pattern generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        2: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: in-order delivery and stability under back-pressure.
  logic        stall_q = 1'b0;
  logic [11:0] snap_q  = 12'd0;
  logic [11:0] e_q;
  always @(negedge clk) begin
    if (!reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("stable", 32'({out_valid, out_eop, out_dest, out_data}), 32'({1'b1, snap_q}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(out_valid), 32'd0);
        end else begin
          e_q = exp_q.pop_front();
          check("byte", 32'({out_eop, out_dest, out_data}), 32'(e_q));
        end
      end
      stall_q = out_valid && !out_ready;
      snap_q  = {out_eop, out_dest, out_data};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pay;
    for (int i = 0; i < 32; i++) pay[i] = 8'($urandom);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n);
    model_packet(hdr, n);
    sa_valid = 1'b1;
    sa = hdr;
    tick();
    for (int i = 0; i < n; i++) begin
      sa = pay[i];
      tick();
    end
    sa_valid = 1'b0;
    sa = 8'($urandom);
    tick();
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    check({tag, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_pkt"},  32'(pkt_cnt),  32'(exp_c(exp_pkt)));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_c(exp_drop)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    sa_valid = 1'b0;
    sa = 8'd0;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_dest",  32'(out_dest),  32'd0);
    check("rst_eop",   32'(out_eop),   32'd0);
    check_cnt("rst");
    reset = 1'b1;
    repeat (2) tick();

    // Basic packet and two-edge latency.
    pay[0] = 8'hA0; pay[1] = 8'hA1; pay[2] = 8'hA2;
    model_packet(8'h02, 3);
    sa_valid = 1'b1; sa = 8'h02; tick();
    sa = 8'hA0; tick();
    check("lat0", 32'(out_valid), 32'd0);
    sa = 8'hA1; tick();
    check("lat1", 32'(out_valid), 32'd0);
    sa = 8'hA2; tick();
    check("lat2", 32'(out_valid), 32'd1);
    check("lat2_data", 32'(out_data), 32'h0A0);
    check("lat2_dest", 32'(out_dest), 32'd3);
    sa_valid = 1'b0; tick();
    wait_drain("basic");
    check_cnt("basic");

    // Oversize packet is truncated to MAXP bytes.
    fill_pay();
    send_pkt({6'($urandom), 2'b00}, 20);
    wait_drain("trunc");
    check_cnt("trunc");

    // Header-only packet.
    send_pkt(8'h03, 0);
    wait_drain("hdr_only");
    check_cnt("hdr_only");

    // Back-pressure: third full packet does not fit.
    rdy_mode = 1;
    repeat (2) tick();
    for (int p = 0; p < 3; p++) begin
      fill_pay();
      send_pkt(8'($urandom), 16);
    end
    check_cnt("full");
    rdy_mode = 0;
    wait_drain("full");

    // Toggling ready.
    rdy_mode = 2;
    fill_pay();
    send_pkt(8'($urandom), 8);
    wait_drain("toggle");
    rdy_mode = 0;

    // Random packets, random ready.
    rdy_mode = 3;
    for (int p = 0; p < 30; p++) begin
      fill_pay();
      send_pkt(8'($urandom), $urandom_range(0, 20));
      repeat ($urandom_range(0, 2)) tick();
      wait_drain("rand");
    end
    check_cnt("rand");

    // Reset in the middle of a packet.
    rdy_mode = 1;
    repeat (2) tick();
    fill_pay();
    sa_valid = 1'b1; sa = 8'h41; tick();
    for (int i = 0; i < 5; i++) begin
      sa = pay[i];
      tick();
    end
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_data",  32'(out_data),  32'd0);
    check("mid_dest",  32'(out_dest),  32'd0);
    check("mid_eop",   32'(out_eop),   32'd0);
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    sa = pay[5];
    tick();
    reset = 1'b1;
    rdy_mode = 0;
    for (int i = 6; i < 11; i++) begin
      sa = pay[i];
      tick();
    end
    sa_valid = 1'b0;
    tick();
    wait_drain("mid_drop");
    fill_pay();
    send_pkt(8'($urandom), 6);
    wait_drain("mid_next");
    check("mid_next_pkt", 32'(pkt_cnt), 32'(exp_c(exp_pkt)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
